i2s_rx: RTL and testbench

- I2S receiver (slave): deserialises an external stereo I2S stream (SCLK/LRCLK/SDATA driven by an external ADC or codec) into parallel left/right samples in the clk_sys domain.
- Counterpart to the system's I2S transmitter: same framing, opposite direction.
- Feeds the core's audio-input path, e.g. TAPE_IN-style sampling or passthrough, with a one-cycle pair strobe plus lock/error status.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sync_edge.sv | 40 ++++
 rtl/i2s_rx.sv | 149 ++++++++++++++
 tb/tb_i2s_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and counter sizing, common to the receiver and transmitter.
// Pure declarations: no latency, no flow control.
package i2s_pkg;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    // Bit counter must hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronises sclk/lrclk/sdata into clk and flags sclk rising edges.
// Latency SYNC_STAGES+1 cycles to rise; no backpressure, free-running.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic lrclk,
    input  logic sdata,
    output logic rise,
    output logic lr_s,
    output logic sd_s
);

    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] lr_pipe;
    logic [SYNC_STAGES-1:0] sd_pipe;
    logic                   sclk_prev;

    // Equal depth on all three inputs keeps lrclk/sdata aligned with the detected edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_pipe <= '0;
            lr_pipe   <= '0;
            sd_pipe   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
            lr_pipe   <= {lr_pipe[SYNC_STAGES-2:0], lrclk};
            sd_pipe   <= {sd_pipe[SYNC_STAGES-2:0], sdata};
            sclk_prev <= sclk_pipe[SYNC_STAGES-1];
        end
    end

    assign rise = sclk_pipe[SYNC_STAGES-1] & ~sclk_prev;
    assign lr_s = lr_pipe[SYNC_STAGES-1];
    assign sd_s = sd_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserialises L/R words into clk_sys with pair strobe, frame error and lock status.
// sample_valid one cycle after the R->L transition edge is seen; no backpressure, outputs hold until next pair.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             sample_valid,
    output logic             frame_err,
    output logic             locked
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  TO_DONE  = TW'(TIMEOUT);

    logic             rise;
    logic             lr_s;
    logic             sd_s;

    logic             lr_prev;
    logic             seen;
    logic             pend;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pend_left;
    logic [1:0]       good;
    logic [TW-1:0]    wdog;

    logic             is_trans;
    logic             has_room;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    total;
    logic [WIDTH-1:0] word;
    logic             short_word;
    logic             finalise;
    logic             fin_left;
    logic             fin_right;
    logic             deliver;
    logic             timeout;
    logic             bad;

    i2s_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_sys),
        .reset (reset),
        .sclk  (sclk),
        .lrclk (lrclk),
        .sdata (sdata),
        .rise  (rise),
        .lr_s  (lr_s),
        .sd_s  (sd_s)
    );

    // The transition edge carries the outgoing channel's last bit, so it is folded in before finalising.
    always_comb begin
        is_trans   = rise && (lr_s != lr_prev);
        has_room   = cnt < CNT_FULL;
        sh_next    = has_room ? {shreg[WIDTH-2:0], sd_s} : shreg;
        total      = has_room ? cnt + CW'(1) : cnt;
        word       = sh_next << (CNT_FULL - total);
        short_word = total < CNT_FULL;
        finalise   = is_trans && seen;
        fin_left   = finalise && (lr_prev == LR_LEFT);
        fin_right  = finalise && (lr_prev == LR_RIGHT);
        deliver    = fin_right && pend;
        timeout    = !rise && (wdog == TO_LAST);
        bad        = finalise && short_word;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
            lr_prev      <= LR_LEFT;
            seen         <= 1'b0;
            pend         <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            pend_left    <= '0;
            good         <= '0;
            wdog         <= '0;
        end else begin
            sample_valid <= deliver;
            frame_err    <= bad;

            if (rise) begin
                wdog    <= '0;
                lr_prev <= lr_s;
                if (is_trans) begin
                    cnt   <= '0;
                    shreg <= '0;
                    seen  <= 1'b1;
                    if (fin_left) begin
                        pend_left <= word;
                        pend      <= 1'b1;
                    end
                    if (fin_right) begin
                        pend <= 1'b0;
                    end
                    if (deliver) begin
                        left_chan  <= pend_left;
                        right_chan <= word;
                    end
                end else if (has_room) begin
                    shreg <= sh_next;
                    cnt   <= cnt + CW'(1);
                end
            end else if (timeout) begin
                // Stream lost: forget phase and partial words, but keep the last delivered pair.
                wdog  <= TO_DONE;
                cnt   <= '0;
                shreg <= '0;
                pend  <= 1'b0;
                seen  <= 1'b0;
            end else if (wdog < TO_LAST) begin
                wdog <= wdog + TW'(1);
            end

            if (timeout || bad) begin
                good   <= '0;
                locked <= 1'b0;
            end else if (deliver) begin
                if (good != 2'd2) begin
                    good <= good + 2'd1;
                end
                if (good != 2'd0) begin
                    locked <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an async I2S stream and checks pairs, frame errors, lock and timeout.
module tb_i2s_rx;

    localparam int HALF = 163;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        sample_valid;
    logic        frame_err;
    logic        locked;

    int   checks = 0;
    int   errors = 0;
    int   sv_pulses = 0;
    int   sv_hi = 0;
    int   fe_pulses = 0;
    int   fe_hi = 0;
    logic sv_q = 1'b0;
    logic fe_q = 1'b0;
    logic carry;
    bit   trailed;
    int   base;

    i2s_rx #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (1024)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #10 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (sample_valid) sv_hi++;
        if (sample_valid && !sv_q) sv_pulses++;
        if (frame_err) fe_hi++;
        if (frame_err && !fe_q) fe_pulses++;
        sv_q = sample_valid;
        fe_q = frame_err;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Bit i of a slot (1-based after the transition edge), MSB first, zero beyond the word.
    function automatic logic slot_bit(input logic [15:0] w, input int nbits, input int i);
        if (i >= 1 && i <= nbits) return w[nbits-i];
        return 1'b0;
    endfunction

    task automatic bit_period(input logic lr, input logic d);
        lrclk = lr;
        sdata = d;
        #HALF sclk = 1'b1;
        #HALF sclk = 1'b0;
    endtask

    task automatic play_slot(input logic lr, input logic [15:0] w, input int nbits,
                             input int slot, input int first);
        for (int i = first; i < slot; i++)
            bit_period(lr, (i == 0) ? carry : slot_bit(w, nbits, i));
        carry = slot_bit(w, nbits, slot);
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nbits, input int slot);
        play_slot(1'b0, l, nbits, slot, trailed ? 1 : 0);
        trailed = 1'b0;
        play_slot(1'b1, r, nbits, slot, 0);
    endtask

    // First period of the next left slot: the R->L transition edge.
    task automatic trail();
        bit_period(1'b0, carry);
        trailed = 1'b1;
        wait_clks(12);
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; carry = 1'b0; trailed = 1'b0;
        wait_clks(3);
        chk("rst_left", int'(left_chan), 0);
        chk("rst_right", int'(right_chan), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_locked", int'(locked), 0);
        reset = 1'b0;
        wait_clks(2);

        // Nominal 32-bit slots
        frame(16'h8001, 16'h7FFE, 16, 32);
        frame(16'h8001, 16'h7FFE, 16, 32);
        trail();
        chk("a_pairs1", sv_pulses, 1);
        chk("a_unlocked1", int'(locked), 0);
        frame(16'h8001, 16'h7FFE, 16, 32);
        trail();
        chk("a_left", int'(left_chan), 'h8001);
        chk("a_right", int'(right_chan), 'h7FFE);
        chk("a_pairs2", sv_pulses, 2);
        chk("a_locked", int'(locked), 1);
        chk("a_ferr", fe_pulses, 0);

        // Exact 16-bit slots: LSB on the transition edge
        base = sv_pulses;
        frame(16'hA5A5, 16'h5A5A, 16, 16);
        frame(16'hA5A5, 16'h5A5A, 16, 16);
        trail();
        chk("b_left", int'(left_chan), 'hA5A5);
        chk("b_right", int'(right_chan), 'h5A5A);
        chk("b_pairs", sv_pulses - base, 2);
        chk("b_ferr", fe_pulses, 0);
        chk("b_locked", int'(locked), 1);

        // Short 12-bit slots
        base = sv_pulses;
        frame(16'h0ABC, 16'h0123, 12, 12);
        frame(16'h0ABC, 16'h0123, 12, 12);
        trail();
        chk("c_left", int'(left_chan), 'hABC0);
        chk("c_right", int'(right_chan), 'h1230);
        chk("c_pairs", sv_pulses - base, 2);
        chk("c_ferr", fe_pulses, 4);
        chk("c_ferr_width", fe_hi, fe_pulses);
        chk("c_locked", int'(locked), 0);

        // Relock, then stall sclk
        frame(16'h1357, 16'h2468, 16, 32);
        frame(16'h1357, 16'h2468, 16, 32);
        trail();
        chk("d_locked", int'(locked), 1);
        wait_clks(990);
        chk("d_locked_hold", int'(locked), 1);
        wait_clks(110);
        chk("d_timeout", int'(locked), 0);
        chk("d_left_hold", int'(left_chan), 'h1357);
        chk("d_right_hold", int'(right_chan), 'h2468);
        base = sv_pulses;
        frame(16'h0F0F, 16'hF0F0, 16, 32);
        trail();
        chk("d_phase_only", sv_pulses - base, 0);
        frame(16'h0F0F, 16'hF0F0, 16, 32);
        trail();
        chk("d_pair1_unlocked", int'(locked), 0);
        frame(16'h0F0F, 16'hF0F0, 16, 32);
        trail();
        chk("d_relocked", int'(locked), 1);
        chk("d_left", int'(left_chan), 'h0F0F);
        chk("d_right", int'(right_chan), 'hF0F0);
        chk("d_pairs", sv_pulses - base, 2);

        // Reset mid-left-slot while locked
        for (int i = 1; i <= 8; i++) bit_period(1'b0, slot_bit(16'hC3C3, 16, i));
        chk("e_locked_before", int'(locked), 1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("e_rst_left", int'(left_chan), 0);
        chk("e_rst_right", int'(right_chan), 0);
        chk("e_rst_locked", int'(locked), 0);
        chk("e_rst_valid", int'(sample_valid), 0);
        reset = 1'b0;
        base = sv_pulses;
        for (int i = 9; i < 32; i++) bit_period(1'b0, slot_bit(16'hC3C3, 16, i));
        carry = 1'b0;
        trailed = 1'b0;
        play_slot(1'b1, 16'h3C3C, 16, 32, 0);
        trail();
        chk("e_no_pair", sv_pulses - base, 0);
        frame(16'hC3C3, 16'h3C3C, 16, 32);
        trail();
        chk("e_pair", sv_pulses - base, 1);
        chk("e_left", int'(left_chan), 'hC3C3);
        chk("e_right", int'(right_chan), 'h3C3C);

        // Stream starting in the right channel
        @(negedge clk_sys);
        reset = 1'b1;
        lrclk = 1'b0;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2);
        base = sv_pulses;
        carry = 1'b0;
        trailed = 1'b0;
        play_slot(1'b1, 16'h6666, 16, 32, 0);
        trail();
        chk("f_no_pair", sv_pulses - base, 0);
        frame(16'h1111, 16'h9999, 16, 32);
        trail();
        chk("f_pair", sv_pulses - base, 1);
        chk("f_left", int'(left_chan), 'h1111);
        chk("f_right", int'(right_chan), 'h9999);
        chk("valid_width", sv_hi, sv_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
